// File: rtl/inst_encoder.sv
// Instruction encoder: packs register/immediate fields into a 32-bit word by format,
// range-checks the immediate and delivers words through a 2-entry output FIFO.
`ifndef R_TYPE
`define R_TYPE 3'd0
`define I_TYPE 3'd1
`define S_TYPE 3'd2
`define B_TYPE 3'd3
`define J_TYPE 3'd4
`endif

module inst_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       imm_type,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [7:0]       err_count
);

    // True when the top bits are a pure sign extension (all zeros or all ones).
    function automatic logic uniform21(input logic [20:0] v);
        return (v == {21{1'b0}}) || (v == {21{1'b1}});
    endfunction

    function automatic logic uniform13(input logic [12:0] v);
        return (v == {13{1'b0}}) || (v == {13{1'b1}});
    endfunction

    logic [1:0]       count_q, count_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0][31:0] inst_mem_q, inst_mem_d;
    logic [1:0]       err_mem_q, err_mem_d;
    logic             ready_en_q, ready_en_d;
    logic [CNT_W-1:0] enc_count_q, enc_count_d;
    logic [7:0]       err_count_q, err_count_d;
    logic [31:0]      enc_inst_s;
    logic             enc_err_s;
    logic             push_s;
    logic             pop_s;

    // Format-dependent packing and immediate range check of the current request.
    always_comb begin
        enc_inst_s = 32'h0;
        enc_err_s  = 1'b0;
        case (imm_type)
            `R_TYPE: begin
                enc_inst_s = {funct7, rs2, rs1, funct3, rd, opcode};
                enc_err_s  = 1'b0;
            end
            `I_TYPE: begin
                enc_inst_s = {imm[11:0], rs1, funct3, rd, opcode};
                enc_err_s  = !uniform21(imm[31:11]);
            end
            `S_TYPE: begin
                enc_inst_s = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                enc_err_s  = !uniform21(imm[31:11]);
            end
            `B_TYPE: begin
                enc_inst_s = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode};
                enc_err_s  = !uniform21(imm[31:11]);
            end
            `J_TYPE: begin
                enc_inst_s = {imm[19], imm[9:0], imm[10], imm[18:11], rd, opcode};
                enc_err_s  = !uniform13(imm[31:19]);
            end
            default: begin
                enc_inst_s = 32'h0;
                enc_err_s  = 1'b1;
            end
        endcase
    end

    // Handshake: a full FIFO still accepts when the head leaves in the same cycle.
    always_comb begin
        out_valid = (count_q != 2'd0);
        pop_s     = out_valid && out_ready;
        in_ready  = ready_en_q && ((count_q != 2'd2) || out_ready);
        push_s    = in_valid && in_ready;
        out_inst  = inst_mem_q[rd_ptr_q];
        out_err   = err_mem_q[rd_ptr_q];
        enc_count = enc_count_q;
        err_count = err_count_q;
    end

    // FIFO pointers, storage and delivery counters next state.
    always_comb begin
        ready_en_d  = 1'b1;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        inst_mem_d  = inst_mem_q;
        err_mem_d   = err_mem_q;
        enc_count_d = enc_count_q;
        err_count_d = err_count_q;

        if (push_s) begin
            inst_mem_d[wr_ptr_q] = enc_inst_s;
            err_mem_d[wr_ptr_q]  = enc_err_s;
            wr_ptr_d             = !wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d    = !rd_ptr_q;
            enc_count_d = enc_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (out_err && (err_count_q != 8'hFF)) begin
                err_count_d = err_count_q + 8'd1;
            end else begin
                err_count_d = err_count_q;
            end
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (push_s && !pop_s) begin
            count_d = count_q + 2'd1;
        end else if (pop_s && !push_s) begin
            count_d = count_q - 2'd1;
        end else begin
            count_d = count_q;
        end
    end

    // State registers; reset clears buffered words so out_inst reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q  <= 1'b0;
            count_q     <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            inst_mem_q  <= {2{32'h0}};
            err_mem_q   <= 2'b00;
            enc_count_q <= {CNT_W{1'b0}};
            err_count_q <= 8'd0;
        end else begin
            ready_en_q  <= ready_en_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            inst_mem_q  <= inst_mem_d;
            err_mem_q   <= err_mem_d;
            enc_count_q <= enc_count_d;
            err_count_q <= err_count_d;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder: packing, range errors, FIFO
// back-pressure, counter wrap/saturation and asynchronous reset.
`ifndef R_TYPE
`define R_TYPE 3'd0
`define I_TYPE 3'd1
`define S_TYPE 3'd2
`define B_TYPE 3'd3
`define J_TYPE 3'd4
`endif

module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  imm_type = 3'd0;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [6:0]  funct7 = 7'd0;
    logic [4:0]  rd = 5'd0;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic [31:0] imm = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic        out_err;
    logic [15:0] enc_count;
    logic [7:0]  err_count;

    int err_cnt = 0;
    int chk_cnt = 0;

    inst_encoder #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .imm_type(imm_type), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_err(out_err), .enc_count(enc_count), .err_count(err_count)
    );

    always #5 clk = !clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Independent B-format immediate decoder used for the round-trip check.
    function automatic logic [31:0] dec_b(input logic [31:0] w);
        logic [11:0] f;
        f = {w[31], w[7], w[30:25], w[11:8]};
        return {{20{f[11]}}, f};
    endfunction

    task automatic set_in(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                          input logic [4:0] s2, input logic [31:0] im);
        imm_type = t; opcode = op; funct3 = f3; funct7 = f7;
        rd = d; rs1 = s1; rs2 = s2; imm = im;
    endtask

    // Single request into an empty FIFO: word must appear one cycle after acceptance.
    task automatic issue(input string tag, input logic [31:0] exp_inst, input logic exp_err);
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1 check_eq({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check_eq({tag, "_inst"}, out_inst, exp_inst);
        check_eq({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
    endtask

    logic [31:0] b_word;
    int pushed;
    int popped;

    initial begin
        #3;
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_inst", out_inst, 32'd0);
        check_eq("rst_enc_count", {16'd0, enc_count}, 32'd0);
        check_eq("rst_err_count", {24'd0, err_count}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_eq("rel_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 check_eq("rel_in_ready_high", {31'd0, in_ready}, 32'd1);

        set_in(`I_TYPE, 7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF);
        issue("i_neg1", 32'hFFF1_0093, 1'b0);
        set_in(`S_TYPE, 7'h23, 3'd2, 7'd0, 5'd0, 5'd2, 5'd3, 32'd8);
        issue("s_sw", 32'h0031_2423, 1'b0);

        set_in(`B_TYPE, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'h0000_07FF);
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        b_word = out_inst;
        check_eq("b_inst", b_word, 32'h7E20_8FE3);
        check_eq("b_roundtrip", dec_b(b_word), 32'h0000_07FF);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        set_in(`R_TYPE, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'hDEAD_BEEF);
        issue("r_sub", 32'h4031_00B3, 1'b0);
        set_in(`J_TYPE, 7'h6F, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd1);
        issue("j_one", 32'h0020_02EF, 1'b0);

        set_in(`I_TYPE, 7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'h0000_0800);
        issue("i_range", 32'h8001_0093, 1'b1);
        check_eq("err_count_1", {24'd0, err_count}, 32'd1);
        set_in(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd0);
        issue("bad_type", 32'h0, 1'b1);
        check_eq("err_count_2", {24'd0, err_count}, 32'd2);
        set_in(`J_TYPE, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h0008_0000);
        issue("j_range", 32'h8000_006F, 1'b1);
        check_eq("err_count_3", {24'd0, err_count}, 32'd3);
        check_eq("enc_count_8", {16'd0, enc_count}, 32'd8);

        // Back-pressure: two words buffered, third held until the consumer drains.
        @(negedge clk);
        out_ready = 1'b0;
        set_in(`I_TYPE, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        in_valid = 1'b1;
        @(negedge clk);
        set_in(`I_TYPE, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd2);
        @(negedge clk);
        set_in(`I_TYPE, 7'h13, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd3);
        #1 check_eq("full_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("full_head", out_inst, 32'h0010_0093);
        @(negedge clk);
        check_eq("stall_hold", out_inst, 32'h0010_0093);
        out_ready = 1'b1;
        #1 check_eq("full_pop_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("ord_b", out_inst, 32'h0020_0113);
        @(posedge clk);
        #1 check_eq("ord_c", out_inst, 32'h0030_0193);
        check_eq("ord_c_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1 check_eq("ord_empty", {31'd0, out_valid}, 32'd0);
        check_eq("enc_count_11", {16'd0, enc_count}, 32'd11);
        out_ready = 1'b0;

        // Asynchronous reset between edges with two words buffered.
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_inst", out_inst, 32'd0);
        check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check_eq("post_rst_enc", {16'd0, enc_count}, 32'd0);
        check_eq("post_rst_err", {24'd0, err_count}, 32'd0);
        check_eq("post_rst_empty", {31'd0, out_valid}, 32'd0);

        // Streaming: 70000 words, every other one erroneous.
        pushed = 0;
        popped = 0;
        for (int g = 0; g < 80000 && popped < 70000; g++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (pushed < 70000);
            if (pushed % 2 == 1) set_in(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
            else set_in(`I_TYPE, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
            #1;
            if (in_valid && in_ready) pushed++;
            if (out_valid && out_ready) popped++;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        check_eq("stream_popped", popped, 32'd70000);
        check_eq("wrap_enc_count", {16'd0, enc_count}, 32'd4464);
        check_eq("sat_err_count", {24'd0, err_count}, 32'd255);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the encoded-instruction counter.
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, request present.
REQ-005 SHALL have port in_ready, output, 1, request accepted this cycle when in_valid=1.
REQ-006 SHALL have port imm_type, input, 3, format code from the shared type encoding (`R_TYPE, `I_TYPE, `S_TYPE, `B_TYPE, `J_TYPE).
REQ-007 SHALL have port opcode, input, 7, inst[6:0].
REQ-008 SHALL have port funct3, input, 3, inst[14:12].
REQ-009 SHALL have port funct7, input, 7, inst[31:25], R_TYPE only.
REQ-010 SHALL have ports rd, rs1 and rs2, input, 5 each, register indices.
REQ-011 SHALL have port imm, input, 32, immediate in exactly the units and sign extension the immediate decoder produces; B/J values are in halfword units, unshifted.
REQ-012 SHALL have port out_valid, output, 1, encoded word available.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts the word when out_valid=1.
REQ-014 SHALL have port out_inst, output, 32, encoded instruction word.
REQ-015 SHALL have port out_err, output, 1, error status of out_inst: range error or illegal type.
REQ-016 SHALL have port enc_count, output, CNT_W, number of words delivered, wrapping.
REQ-017 SHALL have port err_count, output, 8, number of erroneous words delivered, saturating at 255.

Function
REQ-018 Field packing SHALL follow the decoder's field layout:
- R: {funct7, rs2, rs1, funct3, rd, opcode}.
- I: {imm[11:0], rs1, funct3, rd, opcode}.
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
- B: {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode}.
- J: {imm[19], imm[9:0], imm[10], imm[18:11], rd, opcode}.
REQ-019 Round-trip SHALL hold: decoding the produced word with the same imm_type returns imm unchanged whenever out_err=0.
REQ-020 The range check SHALL pass when imm[31:11] is all-equal for I, S and B, and when imm[31:19] is all-equal for J; R ignores imm.
REQ-021 A failed range check SHALL still emit the truncated packing with out_err=1.
REQ-022 An imm_type outside the five codes SHALL produce out_inst=32'h0 with out_err=1.
REQ-023 Encoding and checking SHALL be done in a registered stage, with results written into a 2-entry output FIFO.
REQ-024 Minimum latency SHALL be out_valid=1 on the cycle after acceptance.
REQ-025 A transfer on either side SHALL occur only on a cycle where the corresponding valid and ready are both 1.
REQ-026 in_ready SHALL be 1 iff the FIFO holds fewer than 2 entries after accounting for a same-cycle output pop; when full with out_ready=1, input is accepted.
REQ-027 On a simultaneous push and pop, occupancy SHALL be unchanged and order preserved (FIFO).
REQ-028 While out_valid=1 and out_ready=0, out_inst and out_err SHALL hold stable.
REQ-029 Inputs SHALL be sampled only on acceptance; changes while in_ready=0 have no effect.
REQ-030 enc_count SHALL increment by 1 per output transfer and wrap from 2^CNT_W-1 to 0.
REQ-031 err_count SHALL increment per output transfer with out_err=1 and stick at 255.

Reset
REQ-032 While rst_n=0, regardless of clk, SHALL drive out_valid=0, out_inst=0, out_err=0, enc_count=0, err_count=0, FIFO empty, in_ready=0.
REQ-033 in_ready SHALL rise on the first rising clk edge after rst_n deasserts.
REQ-034 Reset mid-operation SHALL discard all buffered words.

Verification
REQ-035 I_TYPE, opcode 0x13, funct3 0, rd 1, rs1 2, imm 0xFFFFFFFF -> out_inst 0xFFF10093, out_err 0, one cycle after accept.
REQ-036 S_TYPE, opcode 0x23, funct3 2, rs1 2, rs2 3, imm 8 -> 0x00312423; B_TYPE imm 0x7FF -> decoder round-trip gives 0x7FF.
REQ-037 I_TYPE imm 0x800 -> out_err 1, err_count 1; imm_type 7 -> out_inst 0, out_err 1, err_count 2.
REQ-038 out_ready=0, three back-to-back requests -> two buffered, in_ready=0, third held; then out_ready=1 -> three words in order, no loss or duplicate.
REQ-039 Push and pop each cycle for 70000 words with CNT_W=16 -> enc_count wraps to 70000-65536=4464, err_count saturates at 255 if errors >255.
REQ-040 Assert rst_n=0 with 2 words buffered, between clock edges -> out_valid falls immediately; counters 0 after release.
